uart_byte_tx: RTL and testbench

UART byte transmitter that serialises the command bytes produced by the AT-command sequencer onto the ESP8266 link. It accepts one byte per `tx_data_valid` pulse, drives `bps_en_tx` high while a frame is in progress so the sequencer waits before presenting the next byte, and drives the `txd` line. The frame format is 8N1 by default.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_gen.sv | 46 ++++
 rtl/uart_byte_tx.sv | 177 +++++++++++++++++
 tb/tb_uart_byte_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART byte transmitter.
//   * default clock / line-rate constants
//   * FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   * calc_div: rounded clocks-per-bit from clock frequency and baud rate
//   * even_parity: XOR of the eight data bits
package uart_pkg;

  localparam int DEF_CLK_FREQ = 32'd50_000_000;
  localparam int DEF_BAUD     = 32'd115_200;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Round to the nearest whole number of clocks per bit.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 32'sd2) / baud;
  endfunction

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- bit-period timer for the UART transmitter.
//   clk     : system clock
//   reset   : asynchronous, active-low reset
//   restart : clears the count so the next tick lands DIV cycles later
//   tick    : registered one-cycle pulse every DIV cycles
module uart_baud_gen #(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          tick_r;

  // Next count: restart wins, otherwise wrap at DIV-1.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (restart) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (cnt_r == CW'(DIV - 1)) begin
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Counter and registered tick; tick is high while the count sits at DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= (cnt_nxt_s == CW'(DIV - 1));
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx -- UART byte transmitter (8N1 by default).
//   clk           : system clock
//   reset         : asynchronous, active-low reset
//   tx_data_valid : single-cycle byte strobe
//   tx_data_in    : byte to send, sampled on acceptance
//   bps_en_tx     : busy, high from the cycle after acceptance to the end of the last stop bit
//   txd           : serial line, idles high
//   tx_done       : one-cycle pulse when a frame completes
//   tx_drop       : one-cycle pulse when a strobe arrives while busy
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after bit 7.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD      = DEF_BAUD,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_data_valid,
  input  logic [7:0] tx_data_in,
  output logic       bps_en_tx,
  output logic       txd,
  output logic       tx_done,
  output logic       tx_drop
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  logic [2:0] state_r,    state_s;
  logic [7:0] shift_r,    shift_s;
  logic [2:0] bit_cnt_r,  bit_cnt_s;
  logic       stop_cnt_r, stop_cnt_s;
  logic       txd_r,      txd_s;
  logic       busy_r,     busy_s;
  logic       done_r,     done_s;
  logic       drop_r,     drop_s;
  logic       accept_s;
  logic       tick_s;
`ifdef UART_TX_PARITY_EN
  logic       parity_r,   parity_s;
`endif

  assign accept_s = tx_data_valid & ~busy_r;

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (accept_s),
    .tick    (tick_s)
  );

  // Frame sequencing: next state, shift register, counters and output levels.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_cnt_s  = bit_cnt_r;
    stop_cnt_s = stop_cnt_r;
    txd_s      = txd_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    drop_s     = tx_data_valid & busy_r;
`ifdef UART_TX_PARITY_EN
    parity_s   = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s    = ST_START;
          shift_s    = tx_data_in;
          bit_cnt_s  = 3'd0;
          stop_cnt_s = 1'b0;
          txd_s      = 1'b0;
          busy_s     = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_s   = even_parity(tx_data_in);
`endif
        end else begin
          txd_s  = 1'b1;
          busy_s = 1'b0;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_s = ST_DATA;
          txd_s   = shift_r[0];
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (bit_cnt_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_s = ST_PARITY;
            txd_s   = parity_r;
`else
            state_s = ST_STOP;
            txd_s   = 1'b1;
`endif
          end else begin
            // Shift first so the next data bit always comes from bit 1.
            bit_cnt_s = bit_cnt_r + 3'd1;
            shift_s   = {1'b0, shift_r[7:1]};
            txd_s     = shift_r[1];
          end
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          state_s = ST_STOP;
          txd_s   = 1'b1;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          if (stop_cnt_r == 1'(STOP_BITS - 1)) begin
            state_s = ST_IDLE;
            txd_s   = 1'b1;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            stop_cnt_s = stop_cnt_r + 1'b1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        txd_s   = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and returns the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      shift_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      drop_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_cnt_r  <= bit_cnt_s;
      stop_cnt_r <= stop_cnt_s;
      txd_r      <= txd_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      drop_r     <= drop_s;
`ifdef UART_TX_PARITY_EN
      parity_r   <= parity_s;
`endif
    end
  end

  assign txd       = txd_r;
  assign bps_en_tx = busy_r;
  assign tx_done   = done_r;
  assign tx_drop   = drop_r;

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx -- scoreboard bench for uart_byte_tx.
// Stimulus pushes each accepted byte into a queue; a line monitor decodes txd
// cycle by cycle against the frame the byte should produce.
module tb_uart_byte_tx;

  localparam int DIV = (50_000_000 + 115_200 / 2) / 115_200;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F  = 1 + 8 + P + 1;
  localparam int F2 = 1 + 8 + P + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_data_valid = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       bps_en_tx, txd, tx_done, tx_drop;

  logic       valid2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       busy2, txd2, done2, drop2;

  int n_cmp = 0;
  int n_fail = 0;
  int n_sent = 0;
  int n_abort = 0;
  int frames_rx = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  logic expect_abort = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_byte_tx u_dut (
    .clk(clk), .reset(reset), .tx_data_valid(tx_data_valid), .tx_data_in(tx_data_in),
    .bps_en_tx(bps_en_tx), .txd(txd), .tx_done(tx_done), .tx_drop(tx_drop)
  );

  uart_byte_tx #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .tx_data_valid(valid2), .tx_data_in(data2),
    .bps_en_tx(busy2), .txd(txd2), .tx_done(done2), .tx_drop(drop2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Line level of bit i of the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (P == 1 && i == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (bps_en_tx !== 1'b0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Sequencer-style send: wait for idle, one-cycle strobe, check first busy cycle.
  task automatic send(input logic [7:0] b);
    wait_idle();
    tx_data_in    = b;
    tx_data_valid = 1'b1;
    exp_q.push_back(b);
    n_sent++;
    @(negedge clk);
    check("busy_after_accept", bps_en_tx, 32'd1);
    check("txd_start", txd, 32'd0);
    tx_data_valid = 1'b0;
    tx_data_in    = 8'($urandom);
  endtask

  // Line monitor: decode each frame cycle by cycle against the queued byte.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          logic [7:0] b;
          bit aborted;
          b = exp_q.pop_front();
          aborted = 1'b0;
          for (int i = 0; i < F && !aborted; i++) begin
            int errs = 0;
            for (int c = 0; c < DIV && !aborted; c++) begin
              if (i != 0 || c != 0) @(negedge clk);
              if (reset !== 1'b1) aborted = 1'b1;
              else if (txd !== frame_bit(b, i)) errs++;
            end
            if (!aborted) check($sformatf("byte%02h_bit%0d", b, i), errs, 32'd0);
          end
          if (aborted) begin
            check("abort_expected", expect_abort, 32'd1);
            expect_abort = 1'b0;
          end else begin
            frames_rx++;
          end
        end
      end
    end
  end

  // Busy-length, done-alignment and pulse counters for the main instance.
  initial begin
    int run = 0;
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) done_cnt++;
      if (tx_drop === 1'b1) drop_cnt++;
      if (reset !== 1'b1) begin
        run = 0;
      end else if (bps_en_tx === 1'b1) begin
        run++;
      end else begin
        if (run > 0) begin
          check("busy_len", run, DIV * F);
          check("done_on_fall", tx_done, 32'd1);
        end
        run = 0;
      end
    end
  end

  initial begin
    int t, lows, highs, exp_lows, done_before;
    logic [7:0] ff_byte;
    logic [7:0] at_str[4];
    at_str[0] = 8'h41; at_str[1] = 8'h54; at_str[2] = 8'h0D; at_str[3] = 8'h0A;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 32'd1);
    check("rst_busy", bps_en_tx, 32'd0);
    check("rst_done", tx_done, 32'd0);
    check("rst_drop", tx_drop, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Two stop bits, byte 0xFF on the second instance
    ff_byte = 8'hFF;
    data2  = ff_byte;
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    exp_lows = 0;
    for (int i = 0; i < F2; i++) if (frame_bit(ff_byte, i) == 1'b0) exp_lows += DIV;
    t = 0; lows = 0; highs = 0;
    while (busy2 === 1'b1 && t < 8000) begin
      if (txd2 === 1'b0) lows++; else highs++;
      @(negedge clk);
      t++;
    end
    check("sb2_busy_len", t, DIV * F2);
    check("sb2_low_cycles", lows, exp_lows);
    check("sb2_high_cycles", highs, DIV * F2 - exp_lows);
    check("sb2_done", done2, 32'd1);
    check("sb2_txd_idle", txd2, 32'd1);

    // Single byte 0x41
    send(8'h41);
    wait_idle();

    // "AT\r\n" back to back with the sequencer handshake
    for (int i = 0; i < 4; i++) send(at_str[i]);
    wait_idle();

    // Strobes while busy: at cycle 1000 and in the final cycle of the stop bit
    send(8'h41);
    repeat (999) @(negedge clk);
    tx_data_in = 8'h55; tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    check("drop_mid", tx_drop, 32'd1);
    @(negedge clk);
    check("drop_single", tx_drop, 32'd0);
    repeat (DIV * F - 1 - 1001) @(negedge clk);
    check("busy_last_cycle", bps_en_tx, 32'd1);
    tx_data_in = 8'h55; tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    check("drop_last_stop", tx_drop, 32'd1);
    check("busy_fall", bps_en_tx, 32'd0);
    check("done_last", tx_done, 32'd1);

    // Reset during bit 3, then 0x0D
    send(8'h41);
    repeat (DIV * 4 + DIV / 2) @(negedge clk);
    done_before = done_cnt;
    expect_abort = 1'b1;
    n_abort++;
    #2 reset = 1'b0;
    #1;
    check("abort_txd", txd, 32'd1);
    check("abort_busy", bps_en_tx, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, done_before);
    send(8'h0D);

    // Random bytes
    for (int i = 0; i < 5; i++) send(8'($urandom));
    wait_idle();
    repeat (3) @(negedge clk);

    check("queue_empty", exp_q.size(), 32'd0);
    check("abort_seen", expect_abort, 32'd0);
    check("frames_rx", frames_rx, n_sent - n_abort);
    check("done_count", done_cnt, n_sent - n_abort);
    check("drop_count", drop_cnt, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
